hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MUL_LAT, default 4, meaning the number of cycles a multiply occupies EX; legal range 2..16.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have inputs id_valid (1), id_rs1 (5), id_rs2 (5), id_rs2_used (1), id_fp (1), id_mul (1): the decoded instruction currently in ID.
REQ-005 SHALL have inputs ex_rd (5), ex_memRd (1), ex_regWr (1), ex_fp (1): the instruction currently in EX.
REQ-006 SHALL have input mem_taken, 1 bit: a branch or jump resolved taken in MEM this cycle.
REQ-007 SHALL have outputs pc_stall, ifid_stall, idex_stall, idex_bubble, exmem_bubble, 1 bit each: hold or NOP-insert controls.
REQ-008 SHALL have outputs ifid_flush, idex_flush, exmem_flush, 1 bit each: squash the younger stages.
REQ-009 SHALL have outputs mul_busy, mul_done, mul_kill (1 bit each) and stall_cycles (16 bits, performance counter).

Function
REQ-010 SHALL detect load-use when ex_memRd & ex_regWr & (ex_fp==id_fp) & id_valid & (ex_rd==id_rs1 | (id_rs2_used & ex_rd==id_rs2)), excluding ex_rd==0 when ex_fp==0.
REQ-011 SHALL, on load-use in IDLE or DONE with mem_taken=0, assert pc_stall, ifid_stall, idex_bubble combinationally for exactly that cycle.
REQ-012 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-013 SHALL issue a multiply in IDLE or DONE when id_valid & id_mul & no load-use & mem_taken=0: next state BUSY, counter loaded with MUL_LAT-2.
REQ-014 SHALL decrement the counter each cycle in BUSY, move to DONE when it reaches 0, and stay in BUSY otherwise.
REQ-015 SHALL, in BUSY, assert pc_stall, ifid_stall, idex_stall, exmem_bubble, mul_busy; load-use detection is ignored.
REQ-016 SHALL, in DONE, pulse mul_done for one cycle with no stalls; next state is BUSY if REQ-013 holds, else IDLE.
REQ-017 SHALL, on mem_taken in any state, assert ifid_flush, idex_flush, exmem_flush and suppress every stall/bubble output that cycle (flush wins).
REQ-018 SHALL, on mem_taken while in BUSY, pulse mul_kill and go to IDLE next cycle; DONE with mem_taken goes to IDLE without mul_kill.
REQ-019 SHALL increment stall_cycles each cycle pc_stall=1, saturating at 16'hFFFF.
REQ-020 SHALL drive every control output combinationally from current state and inputs, with no added latency.

Reset
REQ-021 SHALL, while rst_n=0, force state IDLE, counter 0, stall_cycles 0; all 1-bit outputs 0 unless mem_taken/load-use inputs demand otherwise.
REQ-022 SHALL, on reset mid-multiply, abandon the multiply without pulsing mul_done or mul_kill.

Structure
REQ-023 SHALL place FSM state encoding and the MUL_LAT default in the shared pipeline package.
REQ-024 SHALL implement load-use comparison as sub-module hazard_cmp (combinational), instantiated once.

Verification
REQ-025 SHALL cover: EX lw r5 (ex_memRd=1, ex_regWr=1, ex_rd=5), ID add id_rs1=5 -> pc_stall=ifid_stall=idex_bubble=1 for one cycle; stall_cycles=1.
REQ-026 SHALL cover: ex_rd=0, ex_fp=0, id_rs1=0 -> no stall; same with ex_fp=id_fp=1 -> stall.
REQ-027 SHALL cover: MUL_LAT=4, mul issued at C0 -> mul_busy C1..C3, mul_done at C4, stall_cycles=3, IDLE at C5.
REQ-028 SHALL cover: mem_taken at C2 of a multiply -> three flushes at C2, no stalls at C2, mul_kill at C2, IDLE at C3.
REQ-029 SHALL cover: load-use and mem_taken in the same cycle -> flushes only; back-to-back muls -> second issues from DONE.
REQ-030 SHALL cover: rst_n low at C2 of a multiply -> IDLE immediately, no mul_done; saturation of stall_cycles at 16'hFFFF.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller.
//   MUL_LAT_DEF : default multiply occupancy of EX, in cycles
//   CNT_W       : width of the multiply countdown (covers MUL_LAT up to 16)
//   mul_state_e : multiply sequencing states
package hazard_ctrl_pkg;
  localparam int MUL_LAT_DEF = 4;
  localparam int CNT_W       = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mul_state_e;
endpackage

// File: rtl/hazard_cmp.sv
// Load-use comparator: flags an ID instruction that reads the destination
// of a load sitting in EX.
//   inputs : ID operand fields (valid, rs1, rs2, rs2_used, fp) and
//            EX destination fields (rd, memRd, regWr, fp)
//   output : load_use
module hazard_cmp (
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_rs2_used,
  input  logic       id_fp,
  input  logic [4:0] ex_rd,
  input  logic       ex_memRd,
  input  logic       ex_regWr,
  input  logic       ex_fp,
  output logic       load_use
);
  logic src_hit;
  logic rd_zero;

  assign src_hit = (ex_rd == id_rs1) || (id_rs2_used && (ex_rd == id_rs2));
  // Integer x0 is hardwired zero and never a real dependency; f0 is.
  assign rd_zero = (ex_rd == 5'd0) && !ex_fp;

  assign load_use = ex_memRd && ex_regWr && (ex_fp == id_fp) && id_valid &&
                    src_hit && !rd_zero;
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, multi-cycle multiply
// sequencing in EX, and taken-branch flushes from MEM.
//   clk, rst_n       : clock, async active-low reset
//   id_*             : decoded instruction in ID
//   ex_*             : instruction in EX
//   mem_taken        : branch/jump resolved taken in MEM
//   *_stall/*_bubble : hold / NOP-insert controls
//   *_flush          : squash younger stages
//   mul_busy/done/kill, stall_cycles : multiply status and stall counter
// All control outputs are combinational from state and inputs.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_rs2_used,
  input  logic        id_fp,
  input  logic        id_mul,
  input  logic [4:0]  ex_rd,
  input  logic        ex_memRd,
  input  logic        ex_regWr,
  input  logic        ex_fp,
  input  logic        mem_taken,
  output logic        pc_stall,
  output logic        ifid_stall,
  output logic        idex_stall,
  output logic        idex_bubble,
  output logic        exmem_bubble,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exmem_flush,
  output logic        mul_busy,
  output logic        mul_done,
  output logic        mul_kill,
  output logic [15:0] stall_cycles
);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT - 2);

  mul_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic             load_use;
  logic             busy;
  logic             lu_stall;
  logic             issue;

  hazard_cmp u_cmp (
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs2_used (id_rs2_used),
    .id_fp       (id_fp),
    .ex_rd       (ex_rd),
    .ex_memRd    (ex_memRd),
    .ex_regWr    (ex_regWr),
    .ex_fp       (ex_fp),
    .load_use    (load_use)
  );

  assign busy     = (state == ST_BUSY);
  // Load-use only matters outside BUSY; a taken branch squashes it anyway.
  assign lu_stall = load_use && !busy && !mem_taken;
  assign issue    = !busy && id_valid && id_mul && !load_use && !mem_taken;

  assign ifid_flush   = mem_taken;
  assign idex_flush   = mem_taken;
  assign exmem_flush  = mem_taken;
  assign pc_stall     = (busy && !mem_taken) || lu_stall;
  assign ifid_stall   = pc_stall;
  assign idex_stall   = busy && !mem_taken;
  assign exmem_bubble = busy && !mem_taken;
  assign idex_bubble  = lu_stall;
  assign mul_busy     = busy;
  assign mul_done     = (state == ST_DONE);
  assign mul_kill     = busy && mem_taken;

  // Counter loads MUL_LAT-2 so BUSY spans MUL_LAT-1 cycles and DONE the last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_BUSY: begin
          if (mem_taken)       state <= ST_IDLE;
          else if (cnt == '0)  state <= ST_DONE;
          else                 cnt   <= cnt - 1'b1;
        end
        ST_IDLE, ST_DONE: begin
          if (issue) begin
            state <= ST_BUSY;
            cnt   <= CNT_LOAD;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   stall_cycles <= '0;
    else if (pc_stall && stall_cycles != 16'hFFFF) stall_cycles <= stall_cycles + 16'd1;
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic id_valid = 0, id_rs2_used = 0, id_fp = 0, id_mul = 0;
  logic [4:0] id_rs1 = 0, id_rs2 = 0, ex_rd = 0;
  logic ex_memRd = 0, ex_regWr = 0, ex_fp = 0, mem_taken = 0;
  logic pc_stall, ifid_stall, idex_stall, idex_bubble, exmem_bubble;
  logic ifid_flush, idex_flush, exmem_flush, mul_busy, mul_done, mul_kill;
  logic [15:0] stall_cycles;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MUL_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs2_used(id_rs2_used), .id_fp(id_fp), .id_mul(id_mul),
    .ex_rd(ex_rd), .ex_memRd(ex_memRd), .ex_regWr(ex_regWr), .ex_fp(ex_fp),
    .mem_taken(mem_taken),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .idex_stall(idex_stall),
    .idex_bubble(idex_bubble), .exmem_bubble(exmem_bubble),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .mul_busy(mul_busy), .mul_done(mul_done), .mul_kill(mul_kill),
    .stall_cycles(stall_cycles)
  );

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Multiply tracked as "BUSY cycles still to go" plus a done flag.
  int busy_left = 0;
  bit done_now = 0;
  int stall_m = 0;

  function automatic bit lu_f();
    bit hit;
    hit = (ex_rd == id_rs1) || (id_rs2_used && ex_rd == id_rs2);
    return ex_memRd && ex_regWr && (ex_fp == id_fp) && id_valid && hit &&
           !(ex_rd == 5'd0 && !ex_fp);
  endfunction

  // {pc,ifid,idex_stall,idex_bubble,exmem_bubble,3 flushes,busy,done,kill}
  function automatic logic [10:0] exp_ctrl();
    bit b, s, lb;
    b  = busy_left > 0;
    s  = !mem_taken && b;
    lb = !mem_taken && !b && lu_f();
    return {s | lb, s | lb, s, lb, s, {3{mem_taken}}, b, done_now, b & mem_taken};
  endfunction

  function automatic logic [10:0] dut_ctrl();
    return {pc_stall, ifid_stall, idex_stall, idex_bubble, exmem_bubble,
            ifid_flush, idex_flush, exmem_flush, mul_busy, mul_done, mul_kill};
  endfunction

  task automatic model_reset();
    busy_left = 0; done_now = 0; stall_m = 0;
  endtask

  initial begin : compare
    logic [10:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) model_reset();
      chk("ctrl", 32'(dut_ctrl()), 32'(exp_ctrl()));
      chk("stall_cycles", 32'(stall_cycles), 32'(stall_m));
      @(posedge clk);
      if (!rst_n) model_reset();
      else begin
        e = exp_ctrl();
        if (e[10] && stall_m < 65535) stall_m++;
        if (mem_taken) begin
          busy_left = 0; done_now = 0;
        end else if (busy_left > 0) begin
          busy_left--;
          done_now = (busy_left == 0);
        end else begin
          done_now = 0;
          if (id_valid && id_mul && !lu_f()) busy_left = LAT - 1;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic clr();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs2_used = 0; id_fp = 0; id_mul = 0;
    ex_rd = 0; ex_memRd = 0; ex_regWr = 0; ex_fp = 0; mem_taken = 0;
  endtask

  task automatic set_lu();
    ex_memRd = 1; ex_regWr = 1; ex_rd = 5'd5; id_valid = 1; id_rs1 = 5'd5;
  endtask

  task automatic issue_mul();
    id_valid = 1; id_mul = 1;
  endtask

  initial begin
    clr();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", 32'(dut_ctrl()), 32'd0);
    chk("rst_stall", 32'(stall_cycles), 32'd0);

    // load-use lw r5 -> add r5
    nxt(); rst_n = 1; set_lu();
    @(negedge clk);
    chk("lu_pc_stall", 32'(pc_stall), 1);
    chk("lu_ifid_stall", 32'(ifid_stall), 1);
    chk("lu_idex_bubble", 32'(idex_bubble), 1);
    nxt(); clr();
    @(negedge clk);
    chk("lu_release", 32'(pc_stall), 0);
    chk("lu_count", 32'(stall_cycles), 1);

    // x0 is not a dependency, f0 is
    nxt(); ex_memRd = 1; ex_regWr = 1; ex_rd = 0; id_rs1 = 0; id_valid = 1;
    @(negedge clk); chk("x0_nostall", 32'(pc_stall), 0);
    nxt(); ex_fp = 1; id_fp = 1;
    @(negedge clk); chk("f0_stall", 32'(pc_stall), 1);
    nxt(); clr(); rst_n = 0;
    nxt(); rst_n = 1;

    // multiply, MUL_LAT=4
    issue_mul();
    @(negedge clk); chk("mul_c0_busy", 32'(mul_busy), 0);
    nxt(); clr();
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk); chk("mul_busy_c1_3", 32'(mul_busy), 1);
      nxt();
    end
    @(negedge clk);
    chk("mul_done_c4", 32'(mul_done), 1);
    chk("mul_stall_cnt", 32'(stall_cycles), 3);
    nxt();
    @(negedge clk); chk("mul_idle_c5", 32'({mul_busy, mul_done}), 0);

    // kill by taken branch at C2
    nxt(); issue_mul();
    nxt(); clr();
    nxt(); mem_taken = 1;
    @(negedge clk);
    chk("kill_flush", 32'({ifid_flush, idex_flush, exmem_flush}), 32'h7);
    chk("kill_nostall", 32'({pc_stall, idex_stall, exmem_bubble}), 0);
    chk("kill_pulse", 32'(mul_kill), 1);
    nxt(); clr();
    @(negedge clk); chk("kill_idle", 32'({mul_busy, mul_done, mul_kill}), 0);

    // load-use with taken branch: flush wins
    nxt(); set_lu(); mem_taken = 1;
    @(negedge clk);
    chk("lu_br_flush", 32'({ifid_flush, idex_flush, exmem_flush}), 32'h7);
    chk("lu_br_nostall", 32'({pc_stall, ifid_stall, idex_bubble}), 0);

    // back-to-back multiplies, second issues from DONE
    nxt(); clr(); issue_mul();
    nxt(); clr();
    repeat (3) nxt();
    issue_mul();
    @(negedge clk); chk("b2b_done", 32'(mul_done), 1);
    nxt(); clr();
    @(negedge clk); chk("b2b_busy", 32'(mul_busy), 1);
    repeat (5) nxt();

    // reset mid-multiply
    issue_mul();
    nxt(); clr();
    nxt(); rst_n = 0;
    @(negedge clk);
    chk("rst_mid_ctrl", 32'({mul_busy, mul_done, mul_kill}), 0);
    chk("rst_mid_cnt", 32'(stall_cycles), 0);
    nxt(); rst_n = 1;
    @(negedge clk); chk("rst_mid_nodone", 32'(mul_done), 0);

    // saturation
    nxt(); set_lu();
    repeat (65540) nxt();
    @(negedge clk); chk("sat", 32'(stall_cycles), 32'hFFFF);
    nxt(); clr(); rst_n = 0;
    nxt(); rst_n = 1;

    // randomized traffic, small register range to provoke hits
    for (int i = 0; i < 3000; i++) begin
      id_valid    = ($urandom_range(0, 3) != 0);
      id_rs1      = 5'($urandom_range(0, 3));
      id_rs2      = 5'($urandom_range(0, 3));
      id_rs2_used = 1'($urandom);
      id_fp       = ($urandom_range(0, 3) == 0);
      id_mul      = ($urandom_range(0, 3) == 0);
      ex_rd       = 5'($urandom_range(0, 3));
      ex_memRd    = ($urandom_range(0, 2) == 0);
      ex_regWr    = ($urandom_range(0, 3) != 0);
      ex_fp       = ($urandom_range(0, 3) == 0);
      mem_taken   = ($urandom_range(0, 7) == 0);
      rst_n       = ($urandom_range(0, 199) != 0);
      nxt();
    end
    rst_n = 1; clr();
    @(negedge clk);
    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
